// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// div_issue_ctrl : issue-side controller for the iterative radix-2 divider
//                  (optional operand/result pair cache: DIV_ISSUE_CTRL_PAIR_CACHE_EN)
// Revision       : 1.0
// ============================================================================
module div_issue_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_rem,
  input  logic            in_unsigned,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic            in_flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            div_valid,
  input  logic            div_ready,
  output logic            div_flush,
  output logic            div_w,
  output logic [1:0]      div_signed,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  state_t          state;
  logic            op_rem;
  logic            accept;
  logic [XLEN-1:0] a_prep, b_prep, corner_res, cache_res;
  logic            div_zero, overflow, corner, cache_hit;

  function automatic logic [XLEN-1:0] prep(input logic [XLEN-1:0] v,
                                           input logic word, input logic uns);
    if (!word) return v;
    if (uns)   return {{(XLEN-32){1'b0}}, v[31:0]};
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  // W results are always sign-extended from bit 31, unsigned forms included
  function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] v, input logic word);
    return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready & ~in_flush;
  assign div_valid = (state == REQ) & ~in_flush;
  assign div_flush = (state == WAIT) & in_flush;

  always_comb begin
    a_prep     = prep(in_src1, in_word, in_unsigned);
    b_prep     = prep(in_src2, in_word, in_unsigned);
    div_zero   = (b_prep == '0);
    overflow   = ~in_unsigned & (b_prep == '1) & (a_prep == (in_word ? MIN_W : MIN_D));
    corner     = div_zero | overflow;
    corner_res = fit(in_rem ? (div_zero ? a_prep : '0) : (div_zero ? '1 : a_prep), in_word);
  end

`ifdef DIV_ISSUE_CTRL_PAIR_CACHE_EN
  logic            cache_valid, cache_uns, cache_word, tag_uns;
  logic [XLEN-1:0] cache_quot, cache_rem, cache_src1, cache_src2, tag_src1, tag_src2;

  // Tags hold the raw operands of the op in flight until its completion fills the cache
  always_ff @(posedge clock) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_uns   <= 1'b0;
      cache_word  <= 1'b0;
      cache_quot  <= '0;
      cache_rem   <= '0;
      cache_src1  <= '0;
      cache_src2  <= '0;
      tag_uns     <= 1'b0;
      tag_src1    <= '0;
      tag_src2    <= '0;
    end else begin
      if (accept) begin
        tag_src1 <= in_src1;
        tag_src2 <= in_src2;
        tag_uns  <= in_unsigned;
      end
      if (state == WAIT && div_out_valid) begin
        cache_valid <= 1'b1;
        cache_quot  <= div_quotient;
        cache_rem   <= div_remainder;
        cache_src1  <= tag_src1;
        cache_src2  <= tag_src2;
        cache_uns   <= tag_uns;
        cache_word  <= div_w;
      end
    end
  end

  always_comb begin
    cache_hit = cache_valid & (cache_src1 == in_src1) & (cache_src2 == in_src2) &
                (cache_uns == in_unsigned) & (cache_word == in_word);
    cache_res = fit(in_rem ? cache_rem : cache_quot, in_word);
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      op_rem       <= 1'b0;
      div_w        <= 1'b0;
      div_signed   <= 2'b00;
      div_dividend <= '0;
      div_divisor  <= '0;
      out_result   <= '0;
    end else if (in_flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_rem       <= in_rem;
            div_w        <= in_word;
            div_signed   <= {2{~in_unsigned}};
            div_dividend <= a_prep;
            div_divisor  <= b_prep;
            if (corner) begin
              out_result <= corner_res;
              state      <= DONE;
            end else if (cache_hit) begin
              out_result <= cache_res;
              state      <= DONE;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: if (div_ready) state <= WAIT;
        WAIT: begin
          if (div_out_valid) begin
            out_result <= fit(op_rem ? div_remainder : div_quotient, div_w);
            state      <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_div_issue_ctrl : directed scoreboard bench for div_issue_ctrl with a
//                     behavioural fixed-latency divider
// Revision          : 1.0
// ============================================================================
module tb_div_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid, in_ready, in_rem, in_unsigned, in_word, in_flush;
  logic [63:0] in_src1, in_src2;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic        div_valid, div_ready, div_flush, div_w;
  logic [1:0]  div_signed;
  logic [63:0] div_dividend, div_divisor;
  logic        div_out_valid = 1'b0;
  logic [63:0] div_quotient = '0, div_remainder = '0;

  div_issue_ctrl #(.XLEN(64)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rem(in_rem),
    .in_unsigned(in_unsigned), .in_word(in_word),
    .in_src1(in_src1), .in_src2(in_src2), .in_flush(in_flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .div_valid(div_valid), .div_ready(div_ready), .div_flush(div_flush),
    .div_w(div_w), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_out_valid(div_out_valid), .div_quotient(div_quotient),
    .div_remainder(div_remainder)
  );

  always #5 clock = ~clock;

`ifdef DIV_ISSUE_CTRL_PAIR_CACHE_EN
  localparam int REM_HIT_LAT = 1;
`else
  localparam int REM_HIT_LAT = 67;
`endif

  typedef struct {
    logic [63:0] res;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur = 0;
  bit   prev_ov  = 0;
  int   cyc = 0, total = 0, bad = 0, done_cnt = 0, issued = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Divider model: result pulse 65 (64-bit) or 33 (W) cycles after the request handshake
  bit          busy = 0;
  int          done_at = 0;
  logic [63:0] mq, mr;
  always @(negedge clock) begin
    div_out_valid = 1'b0;
    if (reset || div_flush) begin
      busy = 0;
    end else if (busy && cyc == done_at) begin
      div_out_valid = 1'b1;
      div_quotient  = mq;
      div_remainder = mr;
      busy = 0;
    end
    if (!reset && div_valid && div_ready) begin
      busy    = 1;
      done_at = cyc + (div_w ? 33 : 65);
      if (div_signed == 2'b11) begin
        mq = $signed(div_dividend) / $signed(div_divisor);
        mr = $signed(div_dividend) % $signed(div_divisor);
      end else begin
        mq = div_dividend / div_divisor;
        mr = div_dividend % div_divisor;
      end
    end
  end

  // Monitor: pops the scoreboard when a result appears, rechecks it at the handshake
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
          chk("result", out_result, cur.res);
          chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
        end
      end
      if (out_valid && out_ready && have_cur) begin
        chk("result_at_handshake", out_result, cur.res);
        have_cur = 0;
        done_cnt++;
      end
    end
    prev_ov = out_valid;
  end

  task automatic issue(input bit push, input bit rem, input bit uns, input bit word,
                       input logic [63:0] s1, input logic [63:0] s2,
                       input logic [63:0] res, input int lat,
                       input logic [63:0] ea, input logic [63:0] eb);
    int n = 0;
    @(posedge clock); #1;
    in_valid = 1; in_rem = rem; in_unsigned = uns; in_word = word;
    in_src1 = s1; in_src2 = s2;
    @(negedge clock);
    while (!in_ready && n < 200) begin @(negedge clock); n++; end
    chk("accept_ready", in_ready, 1);
    if (push) exp_q.push_back('{res, cyc, lat});
    @(posedge clock); #1;
    in_valid = 0;
    @(negedge clock);
    if (lat > 1) begin
      chk("div_valid_req", div_valid, 1);
      chk("div_dividend", div_dividend, ea);
      chk("div_divisor", div_divisor, eb);
      chk("div_signed", div_signed, {2{~uns}});
      chk("div_w", div_w, word);
    end else begin
      chk("div_valid_short", div_valid, 0);
    end
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin @(negedge clock); n++; end
    chk("done_count", 64'(done_cnt), 64'(target));
  endtask

  task automatic run(input bit rem, input bit uns, input bit word,
                     input logic [63:0] s1, input logic [63:0] s2,
                     input logic [63:0] res, input int lat,
                     input logic [63:0] ea, input logic [63:0] eb);
    issue(1, rem, uns, word, s1, s2, res, lat, ea, eb);
    issued++;
    wait_done(issued);
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_div_valid"}, div_valid, 0);
    chk({tag, "_div_flush"}, div_flush, 0);
    chk({tag, "_out_result"}, out_result, 64'd0);
    chk({tag, "_dividend"}, div_dividend, 64'd0);
    chk({tag, "_divisor"}, div_divisor, 64'd0);
    chk({tag, "_signed"}, div_signed, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    in_valid = 0; in_rem = 0; in_unsigned = 0; in_word = 0; in_flush = 0;
    in_src1 = '0; in_src2 = '0; out_ready = 1; div_ready = 1; reset = 1;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk_idle_reset("reset");

    run(0, 0, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 67,
        64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
    run(1, 1, 1, 64'hFFFF_FFFF_0000_0007, 64'd2, 64'd1, 35, 64'd7, 64'd2);
    run(0, 0, 0, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, '0, '0);
    run(1, 0, 0, 64'd5, 64'd0, 64'd5, 1, '0, '0);
    run(0, 0, 1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'hFFFF_FFFF_8000_0000, 1, '0, '0);
    run(1, 0, 1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, '0, '0);
    run(0, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h8000_0000_0000_0000, 1, '0, '0);

    // Flush while the divider works: accept at T, flush at T+10
    issue(0, 0, 1, 0, 64'd100, 64'd7, '0, 67, 64'd100, 64'd7);
    repeat (9) @(posedge clock);
    #1 in_flush = 1;
    @(negedge clock);
    chk("flush_div_flush", div_flush, 1);
    @(posedge clock); #1 in_flush = 0;
    @(negedge clock);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_out_valid", out_valid, 0);
    repeat (80) @(negedge clock);
    run(0, 1, 0, 64'd9, 64'd3, 64'd3, 67, 64'd9, 64'd3);

    // Flush together with an offered op in IDLE: op must not be taken
    @(posedge clock); #1;
    in_valid = 1; in_rem = 0; in_unsigned = 0; in_word = 0;
    in_src1 = 64'd1; in_src2 = 64'd0; in_flush = 1;
    @(posedge clock); #1;
    in_valid = 0; in_flush = 0;
    @(negedge clock);
    chk("idle_flush_ready", in_ready, 1);
    chk("idle_flush_out_valid", out_valid, 0);

    // Writeback back-pressure with an unsigned W result that has bit 31 set
    @(posedge clock); #1 out_ready = 0;
    issue(1, 0, 1, 1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 35,
          64'h0000_0000_FFFF_FFFE, 64'd1);
    issued++;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clock); n++; end
    repeat (5) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_result", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
      @(negedge clock);
    end
    @(posedge clock); #1 out_ready = 1;
    wait_done(issued);

    run(0, 0, 0, 64'd100, 64'd7, 64'd14, 67, 64'd100, 64'd7);
    run(1, 0, 0, 64'd100, 64'd7, 64'd2, REM_HIT_LAT, 64'd100, 64'd7);

    // Reset in the middle of a divide, then the same REM must use the divider again
    issue(0, 0, 1, 0, 64'd1000, 64'd7, '0, 67, 64'd1000, 64'd7);
    repeat (5) @(posedge clock);
    #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    chk_idle_reset("midreset");
    repeat (70) @(negedge clock);
    run(1, 0, 0, 64'd100, 64'd7, 64'd2, 67, 64'd100, 64'd7);

    repeat (5) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
